// File: rtl/drive_cmd_tx.sv
// drive_cmd_tx: serial transmitter for drive commands (instruction + torque),
// one UART-style frame per accepted command on a single idle-high wire.
// Ports: clk, reset_n (async, active-low); cmd_valid/cmd_ready handshake;
//   instruction[1:0], torque[2:0] command inputs; tx_line serial output;
//   busy (frame in progress); tx_done (one-cycle pulse on last stop cycle).
// Option: define DRIVE_CMD_TX_PARITY_EN to append an even-parity bit.
module drive_cmd_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_TORQUE   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] instruction,
    input  logic [2:0] torque,
    output logic       tx_line,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [15:0] BIT_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  TQ_MAX   = 3'(MAX_TORQUE);
    localparam logic [2:0]  LAST_IDX = 3'd4;

`ifdef DRIVE_CMD_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [1:0]  inst_q, inst_nxt;
    logic [2:0]  torq_q, torq_nxt;
    logic [2:0]  torque_clamped;
    logic [4:0]  frame_nxt;
    logic        accept;
    logic        bit_end;
    logic        line_nxt;
    logic        done_nxt;
    logic        ready_nxt;
    logic        busy_nxt;

    always_comb begin
        accept         = cmd_valid && cmd_ready;
        bit_end        = (cnt == 16'd0);
        torque_clamped = (torque > TQ_MAX) ? TQ_MAX : torque;
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        inst_nxt       = inst_q;
        torq_nxt       = torq_q;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = START;
                    cnt_nxt   = BIT_LOAD;
                    inst_nxt  = instruction;
                    torq_nxt  = torque_clamped;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    cnt_nxt   = BIT_LOAD;
                    idx_nxt   = 3'd0;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = BIT_LOAD;
                    if (idx == LAST_IDX) begin
`ifdef DRIVE_CMD_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`ifdef DRIVE_CMD_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    cnt_nxt   = BIT_LOAD;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    // a waiting command goes straight into the next
                    // start bit, so back-to-back frames have no gap
                    if (accept) begin
                        state_nxt = START;
                        cnt_nxt   = BIT_LOAD;
                        inst_nxt  = instruction;
                        torq_nxt  = torque_clamped;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 16'd0;
                idx_nxt   = 3'd0;
            end
        endcase

        // outputs are decoded from next-state values and registered,
        // keeping the serial line glitch-free
        frame_nxt = {torq_nxt, inst_nxt};
        line_nxt  = 1'b1;
        unique case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = frame_nxt[idx_nxt];
`ifdef DRIVE_CMD_TX_PARITY_EN
            PARITY:  line_nxt = ^frame_nxt;
`endif
            default: line_nxt = 1'b1;
        endcase

        done_nxt  = (state_nxt == STOP) && (cnt_nxt == 16'd0);
        ready_nxt = (state_nxt == IDLE) || done_nxt;
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            idx       <= 3'd0;
            inst_q    <= 2'd0;
            torq_q    <= 3'd0;
            tx_line   <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            inst_q    <= inst_nxt;
            torq_q    <= torq_nxt;
            tx_line   <= line_nxt;
            busy      <= busy_nxt;
            tx_done   <= done_nxt;
            cmd_ready <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_drive_cmd_tx.sv
// tb_drive_cmd_tx: scoreboard bench for drive_cmd_tx (CLKS_PER_BIT=4).
// A monitor decodes every frame cycle by cycle against queued commands.
module tb_drive_cmd_tx;

    localparam int N = 4;
`ifdef DRIVE_CMD_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 8 : 7;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] instruction;
    logic [2:0] torque;
    logic       tx_line;
    logic       busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int last_gap = 0;
    int frames = 0;
    int aborts = 0;
    logic [4:0] sb[$];

    drive_cmd_tx #(
        .CLKS_PER_BIT(N),
        .MAX_TORQUE  (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .instruction(instruction),
        .torque     (torque),
        .tx_line    (tx_line),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [2:0] clamp(input logic [2:0] t);
        return (t > 3'd4) ? 3'd4 : t;
    endfunction

    function automatic logic [7:0] frame_vec(input logic [4:0] d);
        logic [7:0] v;
        v      = 8'hFF;
        v[0]   = 1'b0;
        v[5:1] = d;
        v[6]   = PAR ? ^d : 1'b1;
        return v;
    endfunction

    // monitor: decodes each frame and compares against the scoreboard
    initial begin : mon
        logic [7:0] ev;
        logic [7:0] ov;
        logic [4:0] d;
        int errs, rdy_errs, dpos, dcnt, bsy_errs;
        bit ab;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n && !tx_line) begin
                last_gap = cyc - last_done_cyc;
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                d = (sb.size() != 0) ? sb.pop_front() : 5'd0;
                ev = frame_vec(d);
                ov = 8'hFF;
                errs = 0;
                rdy_errs = 0;
                bsy_errs = 0;
                dpos = -1;
                dcnt = 0;
                ab = 1'b0;
                for (int p = 0; p < FL * N; p++) begin
                    if (p > 0) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (!reset_n) begin
                        ab = 1'b1;
                        break;
                    end
                    if (tx_line !== ev[p / N]) errs++;
                    if (p % N == N / 2) ov[p / N] = tx_line;
                    if (tx_done) begin
                        dcnt++;
                        dpos = p;
                        last_done_cyc = cyc;
                    end
                    if (busy !== 1'b1) bsy_errs++;
                    if (cmd_ready !== (p == FL * N - 1)) rdy_errs++;
                end
                if (ab) begin
                    aborts++;
                end else begin
                    check("frame_bits", 32'(ov), 32'(ev));
                    check("line_cycle_errs", 32'(errs), 32'd0);
                    check("done_pos", 32'(dpos), 32'(FL * N - 1));
                    check("done_count", 32'(dcnt), 32'd1);
                    check("busy_in_frame", 32'(bsy_errs), 32'd0);
                    check("ready_in_frame", 32'(rdy_errs), 32'd0);
                    frames++;
                end
            end else if (reset_n && tx_done) begin
                check("stray_done", 32'(tx_done), 32'd0);
            end
        end
    end

    task automatic send(input logic [1:0] i, input logic [2:0] t,
                        input bit hold);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid   = 1'b1;
        instruction = i;
        torque      = t;
        for (int n = 0; n < 200; n++) begin
            if (cmd_ready) begin
                sb.push_back({clamp(t), i});
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept_timeout", 32'(ok), 32'd1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sb.size() != 0) && n < 400);
        check("idle_timeout", 32'(n < 400), 32'd1);
    endtask

    logic [1:0] ti [5] = '{2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
    logic [2:0] tt [5] = '{3'd3, 3'd7, 3'd0, 3'd4, 3'd5};

    initial begin
        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        instruction = 2'b00;
        torque      = 3'd0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_line", 32'(tx_line), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(tx_done), 32'd0);
            check("rst_ready", 32'(cmd_ready), 32'd0);
        end
        reset_n = 1'b1;
        #1;
        check("ready_pre_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        for (int k = 0; k < 5; k++) begin
            send(ti[k], tt[k], 1'b0);
            wait_idle();
        end

        // back-to-back with inputs moving while busy
        send(2'b01, 3'd2, 1'b1);
        repeat (6) @(negedge clk);
        instruction = 2'b11;
        torque      = 3'd1;
        repeat (6) @(negedge clk);
        send(2'b10, 3'd6, 1'b0);
        @(negedge clk);
        #1;
        check("b2b_gap", 32'(last_gap), 32'd1);
        wait_idle();

        // reset during data bit 2
        send(2'b10, 3'd1, 1'b0);
        repeat (13) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_line", 32'(tx_line), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(tx_done), 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_done", 32'(tx_done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("aborts", 32'(aborts), 32'd1);

        send(2'b11, 3'd7, 1'b0);
        wait_idle();
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("frames", 32'(frames), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
